// File: rtl/meter_write_arbiter.sv
// meter_write_arbiter
//
// Purpose:
//   Shares the single meter-memory write port among NUM_CORES lockstep DSP
//   cores. Each core's meter write lands in a one-entry slot owned by that
//   core. Occupied slots are drained round-robin, one write per dsp_clk,
//   into the meter memory at address {core_index, core_addr}. The cores
//   cannot stall, so a write that finds its slot still occupied is dropped
//   and counted in a saturating overflow counter.
//
// Optional feature (compile-time macro METER_PEAK_MERGE_EN):
//   When defined, a conflicting write to the same address as the held slot
//   is merged instead of dropped. The slot keeps whichever data word has
//   the larger signed magnitude; the held word wins ties, and the
//   most-negative value counts as the largest magnitude. Conflicting writes
//   to a different address are still dropped and counted. When undefined,
//   every conflicting write is dropped, and no magnitude comparator exists.
//
// Ports:
//   dsp_clk         in   sole clock
//   reset_n         in   asynchronous active-low reset
//   core_wr_en      in   [NUM_CORES] per-core meter write strobe
//   core_wr_addr    in   [NUM_CORES*CORE_ADDR_WIDTH] core i at [i*CORE_ADDR_WIDTH +: CORE_ADDR_WIDTH]
//   core_wr_data    in   [NUM_CORES*DATA_WIDTH] core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mem_wr_en       out  registered meter memory write enable
//   mem_wr_addr     out  registered {core_index, core_addr}
//   mem_wr_data     out  registered write data
//   pending         out  [NUM_CORES] slot-occupied flags
//   overflow_count  out  [CNT_WIDTH] saturating count of dropped writes
//   overflow_clr    in   synchronous clear of overflow_count (beats increments)

module meter_write_arbiter #(
    parameter int NUM_CORES       = 16,
    parameter int DATA_WIDTH      = 36,
    parameter int CORE_ADDR_WIDTH = 8,
    parameter int CORE_IDX_WIDTH  = $clog2(NUM_CORES),
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                     dsp_clk,
    input  logic                                     reset_n,
    input  logic [NUM_CORES-1:0]                     core_wr_en,
    input  logic [NUM_CORES*CORE_ADDR_WIDTH-1:0]     core_wr_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]          core_wr_data,
    output logic                                     mem_wr_en,
    output logic [CORE_IDX_WIDTH+CORE_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                    mem_wr_data,
    output logic [NUM_CORES-1:0]                     pending,
    output logic [CNT_WIDTH-1:0]                     overflow_count,
    input  logic                                     overflow_clr
);

    // Drops in one cycle can reach NUM_CORES, which needs one extra bit.
    localparam int DROP_W = CORE_IDX_WIDTH + 1;
    // Wide enough that counter + drop total can never wrap before saturation.
    localparam int SUM_W  = CNT_WIDTH + DROP_W + 1;

    // Slot storage, one entry per core.
    logic [NUM_CORES-1:0]       slot_valid;
    logic [CORE_ADDR_WIDTH-1:0] slot_addr [NUM_CORES];
    logic [DATA_WIDTH-1:0]      slot_data [NUM_CORES];

    // Round-robin pointer: the first slot examined on the next scan.
    logic [CORE_IDX_WIDTH-1:0]  ptr;

    // Unpacked views of the flat per-core input buses.
    logic [CORE_ADDR_WIDTH-1:0] in_addr [NUM_CORES];
    logic [DATA_WIDTH-1:0]      in_data [NUM_CORES];

    // Grant result for the current cycle.
    logic                       grant_valid;
    logic [CORE_IDX_WIDTH-1:0]  grant_idx;
    logic [CORE_IDX_WIDTH-1:0]  scan_idx;
    logic [NUM_CORES-1:0]       grant_hit;

    // Per-slot capture decisions.
    logic [NUM_CORES-1:0]       slot_accept;
    logic [NUM_CORES-1:0]       slot_drop;
    logic [DROP_W-1:0]          drop_total;
    logic [SUM_W-1:0]           cnt_sum;
    logic [CNT_WIDTH-1:0]       cnt_next;

    assign pending = slot_valid;

    // Slice the flat input buses into per-core arrays so the rest of the
    // logic can index cores directly.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign in_addr[g] = core_wr_addr[g*CORE_ADDR_WIDTH +: CORE_ADDR_WIDTH];
        assign in_data[g] = core_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan: walk ptr, ptr+1, ... and stop at the first occupied
    // slot. NUM_CORES is a power of two, so the index wraps naturally in
    // CORE_IDX_WIDTH bits.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = ptr + CORE_IDX_WIDTH'(k);
            if (!grant_valid && slot_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot view of the grant, used by the per-slot capture logic.
    always_comb begin
        grant_hit = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_hit[i] = grant_valid && (grant_idx == CORE_IDX_WIDTH'(i));
        end
    end

`ifdef METER_PEAK_MERGE_EN
    // Signed magnitude as an unsigned value of the same width. The
    // most-negative input maps to 2^(DATA_WIDTH-1), which is larger than any
    // other magnitude, so it is naturally treated as the maximum.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        magnitude = v[DATA_WIDTH-1] ? (~v + DATA_WIDTH'(1)) : v;
    endfunction

    logic [NUM_CORES-1:0] slot_replace;

    // A write is accepted when its slot is free or is being drained this
    // cycle (the grant carries the old contents). Otherwise it conflicts:
    // same address merges (keeping the strictly larger magnitude), a
    // different address is dropped.
    always_comb begin
        slot_accept  = '0;
        slot_drop    = '0;
        slot_replace = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_accept[i] = core_wr_en[i] && (!slot_valid[i] || grant_hit[i]);
            if (core_wr_en[i] && !slot_accept[i]) begin
                if (in_addr[i] == slot_addr[i]) begin
                    slot_replace[i] = magnitude(in_data[i]) > magnitude(slot_data[i]);
                end else begin
                    slot_drop[i] = 1'b1;
                end
            end
        end
    end
`else
    // A write is accepted when its slot is free or is being drained this
    // cycle (the grant carries the old contents). Any other write finds its
    // slot occupied and is dropped.
    always_comb begin
        slot_accept = '0;
        slot_drop   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_accept[i] = core_wr_en[i] && (!slot_valid[i] || grant_hit[i]);
            slot_drop[i]   = core_wr_en[i] && !slot_accept[i];
        end
    end
`endif

    // Slot registers. A same-cycle accept takes precedence over the grant's
    // clear so the slot stays occupied with the new write.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (slot_accept[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_addr[i]  <= in_addr[i];
                    slot_data[i]  <= in_data[i];
                end else if (grant_hit[i]) begin
                    slot_valid[i] <= 1'b0;
`ifdef METER_PEAK_MERGE_EN
                end else if (slot_replace[i]) begin
                    slot_data[i]  <= in_data[i];
`endif
                end
            end
        end
    end

    // Registered memory write port and pointer advance. With no grant the
    // address/data registers and the pointer simply hold.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            ptr         <= '0;
        end else if (grant_valid) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= {grant_idx, slot_addr[grant_idx]};
            mem_wr_data <= slot_data[grant_idx];
            ptr         <= grant_idx + CORE_IDX_WIDTH'(1);
        end else begin
            mem_wr_en   <= 1'b0;
        end
    end

    // Count this cycle's drops and form the saturated counter update, so
    // several drops in one cycle land as a single step.
    always_comb begin
        drop_total = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drop_total = drop_total + DROP_W'(slot_drop[i]);
        end
        cnt_sum = SUM_W'(overflow_count) + SUM_W'(drop_total);
        if (|cnt_sum[SUM_W-1:CNT_WIDTH]) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // Overflow counter; the clear beats any increment in the same cycle.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (overflow_clr) begin
            overflow_count <= '0;
        end else if (drop_total != '0) begin
            overflow_count <= cnt_next;
        end
    end

endmodule

// File: doc/meter_write_arbiter.md
# meter_write_arbiter

Shares the single meter-memory write port among all `NUM_CORES` DSP cores. Each core's `aux_out_*` meter write is captured into a one-entry per-core slot. Pending slots are drained round-robin, one write per `dsp_clk`, into the meter memory at address `{core_index, core_addr}`. Cores run lockstep and cannot stall, so simultaneous writes are buffered. Writes that cannot be buffered are counted.

## Interface
Parameters:
- `NUM_CORES`, 16, number of requesting cores; power of two, ≥2
- `DATA_WIDTH`, 36, meter word width
- `CORE_ADDR_WIDTH`, 8, per-core meter address width
- `CORE_IDX_WIDTH`, `$clog2(NUM_CORES)`, derived; do not override
- `CNT_WIDTH`, 16, overflow counter width

Ports:
- `dsp_clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `core_wr_en` in `NUM_CORES`: bit *i* = core *i* meter write strobe.
- `core_wr_addr` in `NUM_CORES*CORE_ADDR_WIDTH`: core *i* address at `[i*CORE_ADDR_WIDTH +: CORE_ADDR_WIDTH]`.
- `core_wr_data` in `NUM_CORES*DATA_WIDTH`: core *i* data at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `mem_wr_en` out 1: meter memory write enable.
- `mem_wr_addr` out `CORE_IDX_WIDTH+CORE_ADDR_WIDTH`: `{core_index, core_addr}`.
- `mem_wr_data` out `DATA_WIDTH`: write data.
- `pending` out `NUM_CORES`: slot-occupied flags.
- `overflow_count` out `CNT_WIDTH`: dropped writes, saturating.
- `overflow_clr` in 1: synchronous clear of `overflow_count`.

## Operation
- Per-core slot: `valid`, `addr`, `data`. `pending` = the `valid` vector.
- Round-robin pointer `ptr` (`CORE_IDX_WIDTH` bits). Each cycle the grant goes to the first valid slot scanning `ptr`, `ptr+1`, … modulo `NUM_CORES`.
- On grant *g*:
  - Register `mem_wr_en=1`, `mem_wr_addr={g, slot[g].addr}`, `mem_wr_data=slot[g].data`.
  - Clear `slot[g].valid`.
  - Set `ptr <= g+1`, wrapping.
- No valid slot: `mem_wr_en=0`. `ptr`, `mem_wr_addr` and `mem_wr_data` hold their values.
- Capture when `core_wr_en[i]=1`:
  - Slot *i* empty, or granted this same cycle: load the new write and set `valid`.
  - Otherwise: apply the conflict rule in Configuration.
- Every dropped write increments `overflow_count`. The counter saturates at all-ones.
- Multiple drops in one cycle add their total count in one step, still saturating.
- `overflow_clr` has priority over any increment in the same cycle; the counter becomes 0.

## Timing
- Reset values: `mem_wr_en=0`, `mem_wr_addr=0`, `mem_wr_data=0`, `pending=0`, `overflow_count=0`, `ptr=0`.
- Latency: write captured at edge N. Earliest `mem_wr_en` is visible after edge N+1 (1-cycle minimum latency).
- Throughput: 1 write/cycle. All `NUM_CORES` slots written at once drain in exactly `NUM_CORES` consecutive cycles, in pointer order.
- A new write landing in the same cycle its slot is granted is accepted, not dropped. The grant carries the old contents.
- Reset asserted mid-drain discards all pending writes immediately, with no memory write issued. Outputs return to reset values asynchronously.
- `pending` reflects slot state after the clock edge (registered).

## Configuration
- Macro `METER_PEAK_MERGE_EN`.
- Defined:
  - A conflicting write with the same address as the held slot is merged, not dropped. The slot keeps the data with larger signed magnitude.
  - Magnitude of the most-negative value is treated as the maximum.
  - On a tie the held data is kept.
  - Merges do not count as overflow.
  - A conflicting write with a different address is dropped and counted.
- Undefined: every conflicting write is dropped and counted. No magnitude comparator is synthesized.

## Test plan
- Single write: core 3 writes addr 0x12, data 5 at cycle 0 -> cycle 1: `mem_wr_en=1`, `mem_wr_addr=0x312`, `mem_wr_data=5`; cycle 2: `mem_wr_en=0`.
- Lockstep burst: all 16 cores write addr 0x01, data=i, from reset -> cycles 1..16 output cores 0..15, data 0..15; `pending=0` after cycle 16; `overflow_count=0`.
- Rotation: `ptr=5`, cores 2 and 9 pending -> core 9 granted first, then core 2; `ptr` ends at 3.
- Overflow: all cores write on cycles 0 and 1, same address -> `overflow_count=15` (core 0 accepted via same-cycle grant). With `METER_PEAK_MERGE_EN`: count 0 and larger-magnitude data drained.
- Saturation/clear: force 70000 drops -> count holds 0xFFFF. `overflow_clr` coincident with a drop -> 0.
- Reset mid-drain: 16 pending, assert `reset_n=0` after 4 grants -> `mem_wr_en=0` at once, `pending=0`. After release, no stale write emitted.
